// File: rtl/pic_fetch_pkg.sv
// Shared PIC fetch definitions: default widths, opcode patterns and the redirect-source enum.
// Combinational helpers only; no state and no latency.
package pic_fetch_pkg;

  localparam int PIC_ADDR_W  = 9;
  localparam int PIC_INSTR_W = 12;

  localparam logic [11:0] PIC_NOP   = 12'h000;
  localparam logic [2:0]  OP_GOTO   = 3'b101;   // matched against instr[11:9]
  localparam logic [3:0]  OP_CALL   = 4'b1001;  // matched against instr[11:8]
  localparam logic [3:0]  OP_RETLW  = 4'b1000;  // matched against instr[11:8]

  typedef enum logic [2:0] {
    RD_NONE,
    RD_GOTO,
    RD_CALL,
    RD_RET,
    RD_PCL,
    RD_SKIP
  } redir_e;

  function automatic logic is_goto(input logic [11:0] instr);
    return instr[11:9] == OP_GOTO;
  endfunction

  function automatic logic is_call(input logic [11:0] instr);
    return instr[11:8] == OP_CALL;
  endfunction

  function automatic logic is_retlw(input logic [11:0] instr);
    return instr[11:8] == OP_RETLW;
  endfunction

endpackage

// File: rtl/pic_fetch_if.sv
// Fetch-unit bus: instruction-memory port, core control inputs and the execute slot.
// Fetch has no stall, so there is no ready/backpressure signal.
interface pic_fetch_if #(
  parameter int AW = 9,
  parameter int IW = 12
);

  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_instr;
  logic          skip;
  logic          pcl_we;
  logic [7:0]    pcl_wdata;
  logic [IW-1:0] exec_instr;
  logic          exec_valid;
  logic [AW-1:0] exec_pc;

  modport slave (
    output imem_addr, exec_instr, exec_valid, exec_pc,
    input  imem_instr, skip, pcl_we, pcl_wdata
  );

  modport master (
    input  imem_addr, exec_instr, exec_valid, exec_pc,
    output imem_instr, skip, pcl_we, pcl_wdata
  );

endinterface

// File: rtl/pic_stack2.sv
// Two-level return stack, top in stack0; overflow drops the oldest entry, underflow keeps returning stack1.
// Push/pop take effect on the next clock; rdata is the current top.
module pic_stack2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata
);

  logic [W-1:0] r_stack0;
  logic [W-1:0] r_stack1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stack0 <= '0;
      r_stack1 <= '0;
    end else if (push) begin
      r_stack1 <= r_stack0;
      r_stack0 <= wdata;
    end else if (pop) begin
      r_stack0 <= r_stack1;
    end
  end

  assign rdata = r_stack0;

endmodule

// File: rtl/pic_fetch.sv
// PIC baseline fetch: PC, sync-read imem addressing, branch/skip squash and 2-level call stack.
// One fetch per cycle with no stall; every taken redirect or skip costs exactly one squashed slot.
module pic_fetch
  import pic_fetch_pkg::*;
#(
  parameter int                                L2_PIC_INSTR_MEM_DEPTH = PIC_ADDR_W,
  parameter int                                PIC_INSTR_WIDTH        = PIC_INSTR_W,
  parameter logic [L2_PIC_INSTR_MEM_DEPTH-1:0] RESET_VECTOR           = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  pic_fetch_if.slave   bus
);

  localparam int AW = L2_PIC_INSTR_MEM_DEPTH;

  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_exec_pc;
  logic          r_squash;

  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_pc_nxt;
  logic [AW-1:0] w_stk_rdata;
  logic [11:0]   w_op;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  redir_e        w_redir;

  assign w_valid = ~r_squash;
  assign w_op    = bus.imem_instr[11:0];
  assign w_pc_inc = r_pc + 1'b1;

  assign bus.imem_addr  = r_pc;
  assign bus.exec_valid = w_valid;
  assign bus.exec_instr = w_valid ? bus.imem_instr : PIC_INSTR_WIDTH'(PIC_NOP);
  assign bus.exec_pc    = r_exec_pc;

  // A squashed slot is a bubble: its opcode, skip and pcl_we are all ignored.
  always_comb begin
    w_redir = RD_NONE;
    if (w_valid) begin
      if (is_goto(w_op))       w_redir = RD_GOTO;
      else if (is_call(w_op))  w_redir = RD_CALL;
      else if (is_retlw(w_op)) w_redir = RD_RET;
      else if (bus.pcl_we)     w_redir = RD_PCL;
      else if (bus.skip)       w_redir = RD_SKIP;
    end
  end

  always_comb begin
    w_pc_nxt = w_pc_inc;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    case (w_redir)
      RD_GOTO: w_pc_nxt = AW'(w_op[8:0]);
      RD_CALL: begin
        w_pc_nxt = AW'(w_op[7:0]);
        w_push   = 1'b1;
      end
      RD_RET: begin
        w_pc_nxt = w_stk_rdata;
        w_pop    = 1'b1;
      end
      RD_PCL:  w_pc_nxt = AW'(bus.pcl_wdata);
      default: w_pc_nxt = w_pc_inc;
    endcase
  end

  // r_pc already points past the CALL, so it is the return address.
  pic_stack2 #(.W(AW)) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (r_pc),
    .rdata (w_stk_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_VECTOR;
      r_squash  <= 1'b1;
      r_exec_pc <= '0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_squash  <= (w_redir != RD_NONE);
      r_exec_pc <= r_pc;
    end
  end

endmodule

// File: tb/tb_pic_fetch.sv
// Bench for pic_fetch: sync-read memory model plus an instruction-trace reference model,
// directed scenarios and a randomized program run.
module tb_pic_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pic_fetch_if #(.AW(9), .IW(12)) bus ();

  pic_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [11:0] mem [0:511];
  always @(posedge clk) bus.imem_instr <= mem[bus.imem_addr];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: which address is being fetched, what slot is executing, and the return stack.
  logic [8:0] m_addr;
  logic [8:0] m_pc;
  logic       m_valid;
  logic [8:0] m_stk [$];
  logic [8:0] trace [$];
  logic [8:0] exp_t [$];

  function automatic logic [11:0] m_instr();
    return m_valid ? mem[m_pc] : 12'h000;
  endfunction

  task automatic model_reset();
    m_addr  = 9'h1FF;
    m_pc    = 9'h000;
    m_valid = 1'b0;
    m_stk   = {9'h000, 9'h000};
  endtask

  task automatic model_step(input logic s, input logic p, input logic [7:0] w);
    logic [11:0] ins;
    logic        chg;
    logic [8:0]  tgt;
    ins = mem[m_pc];
    chg = 1'b0;
    tgt = m_addr + 9'd1;
    if (m_valid) begin
      if (ins[11:9] == 3'b101) begin
        chg = 1'b1; tgt = ins[8:0];
      end else if (ins[11:8] == 4'b1001) begin
        chg = 1'b1; tgt = {1'b0, ins[7:0]};
        m_stk.push_front(m_addr);
        if (m_stk.size() > 2) void'(m_stk.pop_back());
      end else if (ins[11:8] == 4'b1000) begin
        chg = 1'b1; tgt = m_stk[0];
        if (m_stk.size() > 1) void'(m_stk.pop_front());
      end else if (p) begin
        chg = 1'b1; tgt = {1'b0, w};
      end else if (s) begin
        chg = 1'b1;
      end
    end
    m_valid = !chg;
    m_pc    = m_addr;
    m_addr  = tgt;
  endtask

  task automatic fill_mem(input logic nops);
    logic [10:0] r;
    for (int i = 0; i < 512; i++) begin
      r = 11'($urandom);
      mem[i] = nops ? 12'h000 : {1'b0, r};
    end
  endtask

  task automatic apply_reset();
    bus.skip = 1'b0; bus.pcl_we = 1'b0; bus.pcl_wdata = 8'h00;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    trace.delete();
  endtask

  task automatic test_reset();
    fill_mem(1'b1);
    bus.skip = 1'b0; bus.pcl_we = 1'b0; bus.pcl_wdata = 8'h00;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.exec_valid, bus.exec_pc, bus.exec_instr, bus.imem_addr} !== {1'b0, 9'h000, 12'h000, 9'h1FF}) begin
      n_err++;
      $display("FAIL reset_hold dut v%b pc%h i%h a%h exp v0 pc000 i000 a1ff",
               bus.exec_valid, bus.exec_pc, bus.exec_instr, bus.imem_addr);
    end
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      n_vec++;
      if ({bus.exec_valid, bus.exec_pc, bus.exec_instr, bus.imem_addr} !== {m_valid, m_pc, m_instr(), m_addr}) begin
        n_err++;
        $display("FAIL reset c%0d dut v%b pc%h i%h a%h exp v%b pc%h i%h a%h", c, bus.exec_valid, bus.exec_pc,
                 bus.exec_instr, bus.imem_addr, m_valid, m_pc, m_instr(), m_addr);
      end
      if (bus.exec_valid) trace.push_back(bus.exec_pc);
      model_step(1'b0, 1'b0, 8'h00);
      @(negedge clk);
    end
    exp_t = {9'h1FF, 9'h000, 9'h001, 9'h002};
    for (int i = 0; i < exp_t.size(); i++) begin
      n_vec++;
      if (i >= trace.size() || trace[i] !== exp_t[i]) begin
        n_err++;
        $display("FAIL reset_trace[%0d] dut %h exp %h", i, (i < trace.size()) ? trace[i] : 9'hxxx, exp_t[i]);
      end
    end
  endtask

  task automatic test_goto();
    fill_mem(1'b0);
    mem[9'h002] = 12'hA05;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      n_vec++;
      if ({bus.exec_valid, bus.exec_pc, bus.exec_instr, bus.imem_addr} !== {m_valid, m_pc, m_instr(), m_addr}) begin
        n_err++;
        $display("FAIL goto c%0d dut v%b pc%h i%h a%h exp v%b pc%h i%h a%h", c, bus.exec_valid, bus.exec_pc,
                 bus.exec_instr, bus.imem_addr, m_valid, m_pc, m_instr(), m_addr);
      end
      if (bus.exec_valid) trace.push_back(bus.exec_pc);
      model_step(1'b0, 1'b0, 8'h00);
      @(negedge clk);
    end
    exp_t = {9'h1FF, 9'h000, 9'h001, 9'h002, 9'h005, 9'h006};
    for (int i = 0; i < exp_t.size(); i++) begin
      n_vec++;
      if (i >= trace.size() || trace[i] !== exp_t[i]) begin
        n_err++;
        $display("FAIL goto_trace[%0d] dut %h exp %h", i, (i < trace.size()) ? trace[i] : 9'hxxx, exp_t[i]);
      end
    end
  endtask

  task automatic test_call_ret();
    fill_mem(1'b0);
    mem[9'h000] = 12'hA10;
    mem[9'h010] = 12'h940;
    mem[9'h040] = 12'h855;
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      n_vec++;
      if ({bus.exec_valid, bus.exec_pc, bus.exec_instr, bus.imem_addr} !== {m_valid, m_pc, m_instr(), m_addr}) begin
        n_err++;
        $display("FAIL call_ret c%0d dut v%b pc%h i%h a%h exp v%b pc%h i%h a%h", c, bus.exec_valid, bus.exec_pc,
                 bus.exec_instr, bus.imem_addr, m_valid, m_pc, m_instr(), m_addr);
      end
      if (bus.exec_valid) trace.push_back(bus.exec_pc);
      model_step(1'b0, 1'b0, 8'h00);
      @(negedge clk);
    end
    exp_t = {9'h1FF, 9'h000, 9'h010, 9'h040, 9'h011, 9'h012};
    for (int i = 0; i < exp_t.size(); i++) begin
      n_vec++;
      if (i >= trace.size() || trace[i] !== exp_t[i]) begin
        n_err++;
        $display("FAIL call_ret_trace[%0d] dut %h exp %h", i, (i < trace.size()) ? trace[i] : 9'hxxx, exp_t[i]);
      end
    end
  endtask

  task automatic test_nested_calls();
    fill_mem(1'b0);
    mem[9'h000] = 12'h910;
    mem[9'h010] = 12'h920;
    mem[9'h020] = 12'h930;
    mem[9'h030] = 12'h800;
    mem[9'h021] = 12'h801;
    mem[9'h011] = 12'h802;
    apply_reset();
    for (int c = 0; c < 18; c++) begin
      n_vec++;
      if ({bus.exec_valid, bus.exec_pc, bus.exec_instr, bus.imem_addr} !== {m_valid, m_pc, m_instr(), m_addr}) begin
        n_err++;
        $display("FAIL nested c%0d dut v%b pc%h i%h a%h exp v%b pc%h i%h a%h", c, bus.exec_valid, bus.exec_pc,
                 bus.exec_instr, bus.imem_addr, m_valid, m_pc, m_instr(), m_addr);
      end
      if (bus.exec_valid) trace.push_back(bus.exec_pc);
      model_step(1'b0, 1'b0, 8'h00);
      @(negedge clk);
    end
    // Third CALL pushed out 0x001, so the last two returns both land on 0x011.
    exp_t = {9'h1FF, 9'h000, 9'h010, 9'h020, 9'h030, 9'h021, 9'h011, 9'h011};
    for (int i = 0; i < exp_t.size(); i++) begin
      n_vec++;
      if (i >= trace.size() || trace[i] !== exp_t[i]) begin
        n_err++;
        $display("FAIL nested_trace[%0d] dut %h exp %h", i, (i < trace.size()) ? trace[i] : 9'hxxx, exp_t[i]);
      end
    end
  endtask

  task automatic test_skip();
    logic s;
    logic p;
    fill_mem(1'b0);
    mem[9'h000] = 12'hA20;
    mem[9'h021] = 12'hA55;
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      n_vec++;
      if ({bus.exec_valid, bus.exec_pc, bus.exec_instr, bus.imem_addr} !== {m_valid, m_pc, m_instr(), m_addr}) begin
        n_err++;
        $display("FAIL skip c%0d dut v%b pc%h i%h a%h exp v%b pc%h i%h a%h", c, bus.exec_valid, bus.exec_pc,
                 bus.exec_instr, bus.imem_addr, m_valid, m_pc, m_instr(), m_addr);
      end
      if (bus.exec_valid) trace.push_back(bus.exec_pc);
      s = (m_pc == 9'h020 && m_valid) || (m_pc == 9'h021 && !m_valid);
      p = (m_pc == 9'h021 && !m_valid);
      bus.skip = s; bus.pcl_we = p; bus.pcl_wdata = 8'h77;
      model_step(s, p, 8'h77);
      @(negedge clk);
    end
    bus.skip = 1'b0; bus.pcl_we = 1'b0;
    exp_t = {9'h1FF, 9'h000, 9'h020, 9'h022, 9'h023, 9'h024};
    for (int i = 0; i < exp_t.size(); i++) begin
      n_vec++;
      if (i >= trace.size() || trace[i] !== exp_t[i]) begin
        n_err++;
        $display("FAIL skip_trace[%0d] dut %h exp %h", i, (i < trace.size()) ? trace[i] : 9'hxxx, exp_t[i]);
      end
    end
  endtask

  task automatic test_pcl_reset();
    logic p;
    logic pulsed;
    fill_mem(1'b0);
    mem[9'h000] = 12'hBF0;
    mem[9'h081] = 12'hB00;
    pulsed = 1'b0;
    apply_reset();
    for (int c = 0; c < 16; c++) begin
      n_vec++;
      if ({bus.exec_valid, bus.exec_pc, bus.exec_instr, bus.imem_addr} !== {m_valid, m_pc, m_instr(), m_addr}) begin
        n_err++;
        $display("FAIL pcl c%0d dut v%b pc%h i%h a%h exp v%b pc%h i%h a%h", c, bus.exec_valid, bus.exec_pc,
                 bus.exec_instr, bus.imem_addr, m_valid, m_pc, m_instr(), m_addr);
      end
      if (bus.exec_valid) trace.push_back(bus.exec_pc);
      if (!pulsed && !m_valid && m_pc == 9'h082) begin
        pulsed = 1'b1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.exec_valid, bus.exec_pc, bus.exec_instr, bus.imem_addr} !== {1'b0, 9'h000, 12'h000, 9'h1FF}) begin
          n_err++;
          $display("FAIL mid_reset dut v%b pc%h i%h a%h exp v0 pc000 i000 a1ff",
                   bus.exec_valid, bus.exec_pc, bus.exec_instr, bus.imem_addr);
        end
        #2 rst_n = 1'b1;
        model_reset();
        bus.skip = 1'b0; bus.pcl_we = 1'b0;
        model_step(1'b0, 1'b0, 8'h00);
      end else begin
        p = (m_valid && m_pc == 9'h1F0);
        bus.skip = 1'b0; bus.pcl_we = p; bus.pcl_wdata = 8'h80;
        model_step(1'b0, p, 8'h80);
      end
      @(negedge clk);
    end
    bus.pcl_we = 1'b0;
    exp_t = {9'h1FF, 9'h000, 9'h1F0, 9'h080, 9'h081, 9'h1FF, 9'h000, 9'h1F0};
    for (int i = 0; i < exp_t.size(); i++) begin
      n_vec++;
      if (i >= trace.size() || trace[i] !== exp_t[i]) begin
        n_err++;
        $display("FAIL pcl_trace[%0d] dut %h exp %h", i, (i < trace.size()) ? trace[i] : 9'hxxx, exp_t[i]);
      end
    end
  endtask

  task automatic test_random();
    logic       s;
    logic       p;
    logic [7:0] w;
    logic [10:0] r;
    for (int run = 0; run < 3; run++) begin
      for (int i = 0; i < 512; i++) begin
        r = 11'($urandom);
        case ($urandom_range(0, 11))
          0:       mem[i] = {3'b101, r[8:0]};
          1:       mem[i] = {4'b1001, r[7:0]};
          2:       mem[i] = {4'b1000, r[7:0]};
          default: mem[i] = {1'b0, r};
        endcase
      end
      apply_reset();
      for (int c = 0; c < 1500; c++) begin
        n_vec++;
        if ({bus.exec_valid, bus.exec_pc, bus.exec_instr, bus.imem_addr} !== {m_valid, m_pc, m_instr(), m_addr}) begin
          n_err++;
          $display("FAIL random r%0d c%0d dut v%b pc%h i%h a%h exp v%b pc%h i%h a%h", run, c, bus.exec_valid,
                   bus.exec_pc, bus.exec_instr, bus.imem_addr, m_valid, m_pc, m_instr(), m_addr);
        end
        s = ($urandom_range(0, 7) == 0);
        p = ($urandom_range(0, 15) == 0);
        w = 8'($urandom);
        bus.skip = s; bus.pcl_we = p; bus.pcl_wdata = w;
        model_step(s, p, w);
        @(negedge clk);
      end
    end
    bus.skip = 1'b0; bus.pcl_we = 1'b0;
  endtask

  initial begin
    bus.skip = 1'b0;
    bus.pcl_we = 1'b0;
    bus.pcl_wdata = 8'h00;
    model_reset();
    test_reset();
    test_goto();
    test_call_ret();
    test_nested_calls();
    test_skip();
    test_pcl_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
